// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for register_file_mp.
//   clr_state_e - clear-engine state encoding (idle / sweeping)
//   width_ok()  - true when an entry width splits into whole bytes
package regfile_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic bit width_ok(input int w);
    return (w > 0) && ((w % 8) == 0);
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: sequenced bulk-clear engine for the register file.
//   clk, reset  - clock, asynchronous active-high reset
//   clr_start   - request a sweep (ignored while one is running)
//   clr_en      - storage should zero entry clr_addr at this edge
//   clr_addr    - entry currently being cleared
//   busy        - sweep in progress (registered, one cycle per entry)
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_start,
  output logic                  clr_en,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  busy
);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        // pointer wraps back to 0 on the final entry, ready for next sweep
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == {ADDR_WIDTH{1'b1}}) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clr_en   = (state_q == ST_CLEAR);
  assign clr_addr = ptr_q;
  assign busy     = clr_en;

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-read-port register file.
//   clk, reset  - clock, asynchronous active-high reset (clears everything)
//   we/wAddr/wData/wBe - byte-enabled write port, dropped while busy
//   rEn/rAddr   - per-port read enable and packed read addresses
//   rData       - packed registered read data (holds when rEn low)
//   rValid      - per-port, high the cycle after a sampled rEn
//   clr_start   - start a bulk clear; busy is high while it sweeps
// Reads are write-first: a same-edge write to the read address is bypassed.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        wAddr,
  input  logic [DATA_WIDTH-1:0]        wData,
  input  logic [DATA_WIDTH/8-1:0]      wBe,
  input  logic [NUM_RD-1:0]            rEn,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rAddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rData,
  output logic [NUM_RD-1:0]            rValid,
  input  logic                         clr_start,
  output logic                         busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  if (!width_ok(DATA_WIDTH)) begin : g_bad_width
    $error("register_file_mp: DATA_WIDTH must be a positive multiple of 8");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;

  regfile_clear_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr (
    .clk       (clk),
    .reset     (reset),
    .clr_start (clr_start),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr),
    .busy      (busy)
  );

  // A write only lands when the sweep is idle; with ZERO_REG, entry 0 is
  // never written so it stays at its reset value of zero.
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] wr_merged;

  assign wr_fire = we && !busy && !((ZERO_REG != 0) && (wAddr == '0));

  always_comb begin
    wr_merged = mem_q[wAddr];
    for (int b = 0; b < NB; b++)
      if (wBe[b]) wr_merged[8*b +: 8] = wData[8*b +: 8];
  end

  // clr_en and wr_fire are mutually exclusive (busy == clr_en).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (clr_en)  mem_d[clr_addr] = '0;
    if (wr_fire) mem_d[wAddr]    = wr_merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    assign addr = rAddr[k*ADDR_WIDTH +: ADDR_WIDTH];

    // Reads see pre-clear contents: the sweep's zeroing is not bypassed.
    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rEn[k];
      if (rEn[k]) begin
        if ((ZERO_REG != 0) && (addr == '0)) rdata_d = '0;
        else if (wr_fire && (wAddr == addr)) rdata_d = wr_merged;
        else                                 rdata_d = mem_q[addr];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign rData[k*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
    assign rValid[k]                         = rvalid_q;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-read-port register file: the successor to the 8×32 single-read-port register file. It adds configurable depth, width and read-port count, byte-enable writes, registered reads with write-first bypass, an optional hardwired-zero entry, and a sequenced bulk-clear engine with a busy flag. It serves as the architectural register store for the datapath experiments that follow the counter/shifter assignments.

## Interface
- DATA_WIDTH, 32, bits per entry; must be a multiple of 8.
- ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH.
- NUM_RD, 2, number of independent read ports (1–4).
- ZERO_REG, 0, if 1 then entry 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- we  in  1  write enable.
- wAddr  in  ADDR_WIDTH  write address.
- wData  in  DATA_WIDTH  write data.
- wBe  in  DATA_WIDTH/8  byte enables; bit i covers wData[8i+7:8i].
- rEn  in  NUM_RD  per-port read enable.
- rAddr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port k uses slice k.
- rData  out  NUM_RD*DATA_WIDTH  packed registered read data.
- rValid  out  NUM_RD  per-port: high one cycle after a sampled rEn.
- clr_start  in  1  request bulk clear of all entries.
- busy  out  1  high while the clear engine runs.

## Operation
- Reset asserted: all entries = 0; rData = 0; rValid = 0; busy = 0; FSM = IDLE; clear pointer = 0.
- Write: at a rising edge with we=1 and busy=0, bytes of mem[wAddr] with wBe set take the corresponding wData bytes. Other bytes are unchanged. wBe=0 is a no-op.
- ZERO_REG=1: writes to address 0 are discarded; reads of address 0 return 0, including via bypass.
- Read port k: at an edge with rEn[k]=1, rData_k is loaded with mem[rAddr_k] and rValid[k]=1 for the next cycle. With rEn[k]=0, rData_k holds and rValid[k]=0.
- Bypass (write-first): if the same edge performs a write to rAddr_k, rData_k gets the merged value (new bytes where wBe is set, old bytes elsewhere).
- All read ports are independent. Any number may address the same entry.
- Clear FSM states:
  - IDLE: clr_start=1 → CLEAR, ptr=0, busy=1.
  - CLEAR: each edge sets mem[ptr]=0 and increments ptr. At the edge clearing DEPTH-1, the FSM returns to IDLE with busy=0.
- clr_start during CLEAR is ignored (no restart).
- While busy=1, writes are dropped and produce no bypass. Reads continue. A read of the entry being cleared on the same edge returns its pre-clear value.
- we and clr_start on the same edge in IDLE: the write completes and the clear starts. The written entry is zeroed later by the sweep.
- Reset during CLEAR aborts the sweep immediately. All entries become 0 regardless.

## Timing
- Read latency is 1 cycle: address and rEn are sampled at edge N, and data/rValid are valid after edge N until edge N+1.
- Write-to-read (different edges): a write at edge N is visible to a read sampled at edge N+1. Via bypass it is visible to a read at edge N itself.
- Clear duration: busy rises after the start edge and stays high exactly DEPTH cycles. The first write is accepted at the edge where busy is sampled 0.
- No combinational path from inputs to outputs.

## Structure
- Package regfile_pkg: FSM state encoding (ST_IDLE, ST_CLEAR) and a width-check function for DATA_WIDTH % 8.
- Sub-module regfile_clear_fsm owns the state, pointer and busy. It exports clr_en and clr_addr to the storage array.
- Read ports are produced by a generate loop over NUM_RD.

## Test plan
- Reset, then write 0x11223344 to addr 2 with wBe=4'hF, then wBe=4'b0010 with data 0xAABBCCDD → addr 2 reads 0x1122CC44 one cycle after rEn.
- Port 0 reads addr 5 on the same edge as a write of 0xDEADBEEF to addr 5 → rData_0=0xDEADBEEF next cycle. Port 1 reads addr 6 (still 0) in parallel → 0.
- ZERO_REG=1: write 0xFFFFFFFF to addr 0, with the same-edge read and a later read → both return 0.
- Fill all 8 entries with 1..8, pulse clr_start → busy high exactly 8 cycles. Writes issued during busy are dropped. All entries read 0 afterwards.
- Assert reset mid-clear at ptr=3 → busy=0 and rValid=0 at once, all entries read 0. A new write after reset is accepted.
- Same-edge we (addr 1, 0x55) and clr_start → addr 1 reads 0x55 before the sweep reaches it, and 0 after busy falls.
